updown_mod_counter: RTL and testbench

- Parametrised synchronous up/down counter; successor to the fixed 4-bit up/down counter.
- Adds generic width and modulus, and selectable wrap or saturate mode.
- Adds count enable, synchronous clear, parallel load, a cascade terminal-count output, a wrap/limit event pulse and a sticky overflow flag.
- Used as a general-purpose counter, timer prescaler, or cascadable stage in larger counters.

---
 rtl/updown_mod_counter.sv | 66 ++++++
 tb/tb_updown_mod_counter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate limit handling, clear, load,
// a combinational cascade terminal count, a limit-event pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxCount = MAX_VAL[WIDTH-1:0];

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] count_d;

  assign at_max = (count == MaxCount);
  assign at_min = (count == '0);

  // A limit event is exactly a counting step taken from the limit in the current direction.
  assign tc = en & ~clr & ~load & ((up & at_max) | (~up & at_min));

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MaxCount) ? MaxCount : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_max)       count_d = count + WIDTH'(1);
        else if (SATURATE) count_d = MaxCount;
        else               count_d = '0;
      end else begin
        if (!at_min)       count_d = count - WIDTH'(1);
        else if (SATURATE) count_d = '0;
        else               count_d = MaxCount;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      evt   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_d;
      evt   <= tc;
      // Set beats clear when both happen on the same edge.
      ovf   <= tc | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: wrap and saturate instances sharing stimulus,
// plus a two-stage decade cascade.
module tb_updown_mod_counter;

  typedef struct packed {
    logic [3:0] count;
    logic       evt;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic       ovf_clr;
    logic [3:0] load_val;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0, c_en = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count_w, count_s, count_c0, count_c1;
  logic       tc_w, evt_w, ovf_w, tc_s, evt_s, ovf_s;
  logic       tc_c0, evt_c0, ovf_c0, tc_c1, evt_c1, ovf_c1;

  int checks   = 0;
  int failures = 0;

  exp_t       sb[$];
  logic [9:0] sbc[$];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(count_w), .tc(tc_w), .evt(evt_w), .ovf(ovf_w)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(count_s), .tc(tc_s), .evt(evt_s), .ovf(ovf_s)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_c0 (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .ovf_clr(1'b0), .count(count_c0), .tc(tc_c0), .evt(evt_c0), .ovf(ovf_c0)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_c1 (
    .clk(clk), .rst(rst), .en(tc_c0), .up(1'b1), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .ovf_clr(1'b0), .count(count_c1), .tc(tc_c1), .evt(evt_c1), .ovf(ovf_c1)
  );

  function automatic exp_t mk(input logic [3:0] c, input logic e, input logic o);
    exp_t r;
    r.count = c;
    r.evt   = e;
    r.ovf   = o;
    return r;
  endfunction

  function automatic stim_t st(input logic e, input logic u, input logic c, input logic l,
                               input logic oc, input logic [3:0] lv);
    stim_t r;
    r.en = e; r.up = u; r.clr = c; r.load = l; r.ovf_clr = oc; r.load_val = lv;
    return r;
  endfunction

  task automatic apply(input stim_t s);
    en = s.en; up = s.up; clr = s.clr; load = s.load; ovf_clr = s.ovf_clr;
    load_val = s.load_val;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({count_w, evt_w, ovf_w} !== 6'b0)
      $display("FAIL reset_async_w: got count=%0d evt=%b ovf=%b, want 0/0/0",
               count_w, evt_w, ovf_w);
    if ({count_w, evt_w, ovf_w} !== 6'b0) failures++;
    checks++;
    if ({count_s, evt_s, ovf_s} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async_s: got count=%0d evt=%b ovf=%b, want 0/0/0",
               count_s, evt_s, ovf_s);
    end
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(4'd0, 1'b0, 1'b0));
      tick;
      e = sb.pop_front();
      checks++;
      if ({count_w, evt_w, ovf_w} !== e) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %0d/%b/%b, want %0d/%b/%b", i,
                 count_w, evt_w, ovf_w, e.count, e.evt, e.ovf);
      end
    end
  endtask

  task automatic test_wrap_up;
    exp_t e;
    apply(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int i = 1; i <= 12; i++) begin
      #1;
      checks++;
      if (tc_w !== (i == 10)) begin
        failures++;
        $display("FAIL wrap_up_tc[%0d]: got %b, want %b", i, tc_w, (i == 10));
      end
      sb.push_back(mk(4'(i % 10), (i == 10), (i >= 10)));
      tick;
      e = sb.pop_front();
      checks++;
      if ({count_w, evt_w, ovf_w} !== e) begin
        failures++;
        $display("FAIL wrap_up[%0d]: got %0d/%b/%b, want %0d/%b/%b", i,
                 count_w, evt_w, ovf_w, e.count, e.evt, e.ovf);
      end
    end
    apply(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
  endtask

  task automatic test_wrap_down_ovf;
    stim_t s[6];
    exp_t  x[6];
    exp_t  e;
    s[0] = st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); x[0] = mk(4'd0, 1'b0, 1'b1);
    s[1] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); x[1] = mk(4'd9, 1'b1, 1'b1);
    s[2] = st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0); x[2] = mk(4'd9, 1'b0, 1'b0);
    s[3] = st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); x[3] = mk(4'd0, 1'b1, 1'b1);
    s[4] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0); x[4] = mk(4'd9, 1'b1, 1'b1);
    s[5] = st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0); x[5] = mk(4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      tick;
      e = sb.pop_front();
      checks++;
      if ({count_w, evt_w, ovf_w} !== e) begin
        failures++;
        $display("FAIL wrap_down_ovf[%0d]: got %0d/%b/%b, want %0d/%b/%b", i,
                 count_w, evt_w, ovf_w, e.count, e.evt, e.ovf);
      end
    end
    apply(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
  endtask

  task automatic test_saturate;
    stim_t s[8];
    exp_t  x[8];
    exp_t  e;
    s[0] = st(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8); x[0] = mk(4'd8, 1'b0, 1'b0);
    s[1] = st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); x[1] = mk(4'd9, 1'b0, 1'b0);
    s[2] = s[1];                                   x[2] = mk(4'd9, 1'b1, 1'b1);
    s[3] = s[1];                                   x[3] = mk(4'd9, 1'b1, 1'b1);
    s[4] = st(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1); x[4] = mk(4'd1, 1'b0, 1'b1);
    s[5] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); x[5] = mk(4'd0, 1'b0, 1'b1);
    s[6] = s[5];                                   x[6] = mk(4'd0, 1'b1, 1'b1);
    s[7] = s[5];                                   x[7] = mk(4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      tick;
      e = sb.pop_front();
      checks++;
      if ({count_s, evt_s, ovf_s} !== e) begin
        failures++;
        $display("FAIL saturate[%0d]: got %0d/%b/%b, want %0d/%b/%b", i,
                 count_s, evt_s, ovf_s, e.count, e.evt, e.ovf);
      end
    end
    apply(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
  endtask

  task automatic test_priority;
    stim_t s[3];
    exp_t  x[3];
    exp_t  e;
    s[0] = st(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);  x[0] = mk(4'd0, 1'b0, 1'b0);
    s[1] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd13); x[1] = mk(4'd9, 1'b0, 1'b0);
    s[2] = st(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);  x[2] = mk(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      #1;
      checks++;
      if (tc_w !== 1'b0) begin
        failures++;
        $display("FAIL priority_tc[%0d]: got %b, want 0", i, tc_w);
      end
      sb.push_back(x[i]);
      tick;
      e = sb.pop_front();
      checks++;
      if ({count_w, evt_w, ovf_w} !== e) begin
        failures++;
        $display("FAIL priority[%0d]: got %0d/%b/%b, want %0d/%b/%b", i,
                 count_w, evt_w, ovf_w, e.count, e.evt, e.ovf);
      end
    end
    apply(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
  endtask

  task automatic test_async_reset;
    exp_t e;
    apply(st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9));
    tick;
    apply(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    sb.push_back(mk(4'd0, 1'b1, 1'b1));
    tick;
    e = sb.pop_front();
    checks++;
    if ({count_w, evt_w, ovf_w} !== e) begin
      failures++;
      $display("FAIL pre_reset_event: got %0d/%b/%b, want %0d/%b/%b",
               count_w, evt_w, ovf_w, e.count, e.evt, e.ovf);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count_w, evt_w, ovf_w} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_w: got %0d/%b/%b, want 0/0/0", count_w, evt_w, ovf_w);
    end
    checks++;
    if ({count_s, evt_s, ovf_s} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_s: got %0d/%b/%b, want 0/0/0", count_s, evt_s, ovf_s);
    end
    tick;
    rst = 1'b0;
    sb.push_back(mk(4'd1, 1'b0, 1'b0));
    tick;
    e = sb.pop_front();
    checks++;
    if ({count_w, evt_w, ovf_w} !== e) begin
      failures++;
      $display("FAIL post_reset_first: got %0d/%b/%b, want %0d/%b/%b",
               count_w, evt_w, ovf_w, e.count, e.evt, e.ovf);
    end
    apply(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
  endtask

  task automatic test_cascade;
    logic [9:0] ec;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      #1;
      checks++;
      if (tc_c0 !== (i % 10 == 0)) begin
        failures++;
        $display("FAIL cascade_tc0[%0d]: got %b, want %b", i, tc_c0, (i % 10 == 0));
      end
      sbc.push_back({4'((i / 10) % 10), 4'(i % 10), (i % 10 == 0), (i == 100)});
      tick;
      ec = sbc.pop_front();
      checks++;
      if ({count_c1, count_c0, evt_c0, evt_c1} !== ec) begin
        failures++;
        $display("FAIL cascade[%0d]: got %0d:%0d evt0=%b evt1=%b, want %0d:%0d evt0=%b evt1=%b",
                 i, count_c1, count_c0, evt_c0, evt_c1, ec[9:6], ec[5:2], ec[1], ec[0]);
      end
    end
    c_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down_ovf();
    test_saturate();
    test_priority();
    test_async_reset();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
